// File: rtl/phase_nco_issuer.sv
// phase_nco_issuer: phase accumulator feeding an iterative CORDIC core.
// Issues one wrapped theta per accepted sample tick, then waits for the core's
// done (or a timeout) before accepting another. Ticks that arrive while busy
// are counted as overruns.
// Optional build macro: PHASE_DITHER_EN adds +/-1 LSB LFSR dither to theta_out.
module phase_nco_issuer #(
   parameter int WIDTH    = 16,
   parameter int PI_Q     = 25736,
   parameter int TWO_PI_Q = 51472,
   parameter int TIMEOUT  = 32,
   parameter int CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    sample_tick,
   input  logic signed [WIDTH-1:0] freq_word,
   input  logic signed [WIDTH-1:0] phase_offset,
   input  logic                    phase_clr,
   input  logic                    cordic_done,
   output logic signed [WIDTH-1:0] theta_out,
   output logic                    theta_valid,
   output logic                    busy,
   output logic [CNT_W-1:0]        overrun_cnt,
   output logic                    timeout_err
);

   // Two guard bits keep acc+operand sums in range before wrapping.
   localparam int IW   = WIDTH + 2;
   localparam int WC_W = $clog2(TIMEOUT + 1);

   localparam logic signed [IW-1:0] PI_S     = IW'(PI_Q);
   localparam logic signed [IW-1:0] NEG_PI_S = -IW'(PI_Q);
   localparam logic signed [IW-1:0] TWO_PI_S = IW'(TWO_PI_Q);
   localparam logic [WC_W-1:0]      WAIT_LAST = WC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  next_state_s;
   logic signed [WIDTH-1:0] acc_r;
   logic [WC_W-1:0]         wait_cnt_r;
   logic                    accept_s;
   logic                    overrun_s;
   logic                    timeout_s;
   logic signed [IW-1:0]    freq_c_s;
   logic signed [IW-1:0]    off_c_s;
   logic signed [IW-1:0]    next_acc_s;
   logic signed [IW-1:0]    theta_calc_s;

   // Limit an operand to [-PI_Q, PI_Q] so a single wrap correction suffices.
   function automatic logic signed [IW-1:0] clamp_pi(input logic signed [IW-1:0] v);
      if (v > PI_S) begin
         return PI_S;
      end else if (v < NEG_PI_S) begin
         return NEG_PI_S;
      end else begin
         return v;
      end
   endfunction

   // Fold a value in [-2*PI, 2*PI) back into [-PI, PI).
   function automatic logic signed [IW-1:0] wrap_pi(input logic signed [IW-1:0] v);
      if (v >= PI_S) begin
         return v - TWO_PI_S;
      end else if (v < NEG_PI_S) begin
         return v + TWO_PI_S;
      end else begin
         return v;
      end
   endfunction

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr_r;
   logic        lfsr_fb_s;

   // Feedback taps for x^16+x^14+x^13+x^11+1 in a right-shifting register.
   assign lfsr_fb_s = lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5];

   // Advance the dither sequence once per issued theta.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r <= 16'hACE1;
      end else if (accept_s) begin
         lfsr_r <= {lfsr_fb_s, lfsr_r[15:1]};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end
`endif

   // Phase arithmetic: clamp inputs, compute next accumulator and issued theta.
   always_comb begin
      freq_c_s   = clamp_pi(IW'(freq_word));
      off_c_s    = clamp_pi(IW'(phase_offset));
      next_acc_s = wrap_pi(IW'(acc_r) + freq_c_s);
`ifdef PHASE_DITHER_EN
      theta_calc_s = clamp_pi(wrap_pi(IW'(acc_r) + off_c_s)
                              + (lfsr_r[0] ? 18'sd1 : -18'sd1));
`else
      theta_calc_s = wrap_pi(IW'(acc_r) + off_c_s);
`endif
   end

   // Next-state logic plus per-cycle accept/overrun/timeout decisions.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      overrun_s    = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable && sample_tick) begin
               next_state_s = ISSUE;
               accept_s     = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            next_state_s = WAIT;
            overrun_s    = enable && sample_tick;
         end
         WAIT: begin
            // A tick coinciding with done is still dropped.
            overrun_s = enable && sample_tick;
            if (cordic_done) begin
               next_state_s = IDLE;
            end else if (wait_cnt_r == WAIT_LAST) begin
               next_state_s = IDLE;
               timeout_s    = 1'b1;
            end else begin
               next_state_s = WAIT;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, accumulator, registered outputs and status counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         wait_cnt_r  <= '0;
         theta_out   <= '0;
         theta_valid <= 1'b0;
         busy        <= 1'b0;
         overrun_cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         theta_valid <= accept_s;
         busy        <= (next_state_s == WAIT);
         if (accept_s) begin
            theta_out <= theta_calc_s[WIDTH-1:0];
         end
         // Clear wins over the accumulate; theta above already used the old acc.
         if (phase_clr) begin
            acc_r <= '0;
         end else if (accept_s) begin
            acc_r <= next_acc_s[WIDTH-1:0];
         end
         if ((state_r == WAIT) && (next_state_s == WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
         end else begin
            wait_cnt_r <= '0;
         end
         if (timeout_s) begin
            timeout_err <= 1'b1;
         end
         if (overrun_s && (overrun_cnt != {CNT_W{1'b1}})) begin
            overrun_cnt <= overrun_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phase_nco_issuer.sv
// Bench for phase_nco_issuer: directed and randomized issues checked against
// an integer-arithmetic reference of the phase rules.
module tb_phase_nco_issuer;

   localparam int PI_Q     = 25736;
   localparam int TWO_PI_Q = 51472;
   localparam int TIMEOUT  = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic               enable;
   logic               sample_tick;
   logic signed [15:0] freq_word;
   logic signed [15:0] phase_offset;
   logic               phase_clr;
   logic               cordic_done;
   logic signed [15:0] theta_out;
   logic               theta_valid;
   logic               busy;
   logic [7:0]         overrun_cnt;
   logic               timeout_err;

   int vectors     = 0;
   int miscompares = 0;

   // reference state
   int acc_m  = 0;
   int ovr_m  = 0;
   int terr_m = 0;
   int last_m = 0;

   phase_nco_issuer dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
      .freq_word(freq_word), .phase_offset(phase_offset), .phase_clr(phase_clr),
      .cordic_done(cordic_done), .theta_out(theta_out), .theta_valid(theta_valid),
      .busy(busy), .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   function automatic int clampq(input int v);
      if (v > PI_Q) return PI_Q;
      if (v < -PI_Q) return -PI_Q;
      return v;
   endfunction

   function automatic int wrapq(input int v);
      if (v >= PI_Q) return v - TWO_PI_Q;
      if (v < -PI_Q) return v + TWO_PI_Q;
      return v;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_status();
      chk("overrun_cnt", int'(overrun_cnt), ovr_m);
      chk("timeout_err", int'(timeout_err), terr_m);
   endtask

   // Issue one theta from IDLE; done_dly < 0 leaves the DUT waiting.
   task automatic issue(input int freq, input int off, input int done_dly, input bit clr);
      int exp_t;
      enable       = 1'b1;
      freq_word    = 16'(freq);
      phase_offset = 16'(off);
      phase_clr    = clr;
      sample_tick  = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      phase_clr   = 1'b0;
      exp_t  = wrapq(acc_m + clampq(off));
      acc_m  = clr ? 0 : wrapq(acc_m + clampq(freq));
      last_m = exp_t;
      chk("theta_valid", int'(theta_valid), 1);
      chk("theta_out", int'(theta_out), exp_t);
      @(negedge clk);
      chk("valid_single", int'(theta_valid), 0);
      chk("busy_wait", int'(busy), 1);
      if (done_dly >= 0) begin
         repeat (done_dly) @(negedge clk);
         cordic_done = 1'b1;
         @(negedge clk);
         cordic_done = 1'b0;
         chk("busy_after_done", int'(busy), 0);
         chk("theta_hold", int'(theta_out), last_m);
      end
   endtask

   task automatic clear_acc();
      phase_clr = 1'b1;
      @(negedge clk);
      phase_clr = 1'b0;
      acc_m = 0;
   endtask

   initial begin
      int cycles;
      logic signed [15:0] rf;
      logic signed [15:0] ro;
      rst = 1'b1; enable = 1'b0; sample_tick = 1'b0; freq_word = '0;
      phase_offset = '0; phase_clr = 1'b0; cordic_done = 1'b0;

      // 1. reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_theta", int'(theta_out), 0);
      chk("rst_valid", int'(theta_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk_status();

      // 2. steady accumulate
      for (int i = 0; i < 4; i++) begin
         issue(1000, 0, 13, 1'b0);
         repeat (4) @(negedge clk);
      end

      // 3. wrap both directions
      clear_acc();
      for (int i = 0; i < 4; i++) issue(20000, 0, 5, 1'b0);
      clear_acc();
      for (int i = 0; i < 3; i++) issue(-20000, 0, 5, 1'b0);

      // 4. offset does not disturb the accumulator
      clear_acc();
      issue(25000, 0, 3, 1'b0);
      issue(0, 1000, 3, 1'b0);
      issue(0, 1000, 3, 1'b0);
      chk("offset_theta", int'(theta_out), -25472);

      // randomized issues incl. out-of-range operands and clear-with-issue
      for (int i = 0; i < 12; i++) begin
         rf = 16'($urandom);
         ro = 16'($urandom);
         issue(int'(rf), int'(ro), int'($urandom_range(0, 25)), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // enable low: ticks ignored, not counted
      enable = 1'b0;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      chk("dis_valid", int'(theta_valid), 0);
      chk("dis_busy", int'(busy), 0);
      chk_status();

      // 5. single overrun while waiting
      issue(500, 0, -1, 1'b0);
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      ovr_m++;
      chk("ovr_no_valid", int'(theta_valid), 0);
      chk_status();
      cordic_done = 1'b1;
      @(negedge clk);
      cordic_done = 1'b0;
      chk("ovr_busy_done", int'(busy), 0);

      // many overruns, including tick coincident with done; must saturate
      freq_word = '0; phase_offset = '0; enable = 1'b1;
      for (int r = 0; r < 16; r++) begin
         sample_tick = 1'b1;
         @(negedge clk);
         last_m = wrapq(acc_m);
         chk("bulk_valid", int'(theta_valid), 1);
         chk("bulk_theta", int'(theta_out), last_m);
         repeat (18) @(negedge clk);
         cordic_done = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
         cordic_done = 1'b0;
         ovr_m = (ovr_m + 19 > 255) ? 255 : ovr_m + 19;
         @(negedge clk);
         chk("bulk_idle", int'(busy), 0);
         if (r == 11) chk_status();
      end
      chk_status();

      // 6. timeout without done
      issue(300, 0, -1, 1'b0);
      cycles = 1;
      while (busy && cycles < 100) begin
         @(negedge clk);
         if (busy) cycles++;
      end
      terr_m = 1;
      chk("timeout_len_ok", int'(cycles >= TIMEOUT && cycles <= TIMEOUT + 1), 1);
      chk_status();
      issue(300, 0, 4, 1'b0);
      chk_status();

      // reset while waiting, then a late done is ignored
      issue(700, 0, -1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acc_m = 0; ovr_m = 0; terr_m = 0;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_theta", int'(theta_out), 0);
      chk_status();
      cordic_done = 1'b1;
      @(negedge clk);
      cordic_done = 1'b0;
      chk("late_done_valid", int'(theta_valid), 0);
      chk("late_done_busy", int'(busy), 0);
      issue(1234, 0, 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
